// File: rtl/riscv_v_pkg.sv
// Shared vector-unit constants and the RF write request record used by the
// writeback arbiter's output stage.
package riscv_v_pkg;

    localparam int RISCV_V_RF_ADDR_WIDTH  = 5;
    localparam int RISCV_V_DATA_WIDTH     = 128;
    localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;

    // One RF write: destination register, data and byte mask.
    typedef struct packed {
        logic [RISCV_V_RF_ADDR_WIDTH-1:0]  addr;
        logic [RISCV_V_DATA_WIDTH-1:0]     data;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] be;
    } rf_wr_req_t;

endpackage

// File: rtl/riscv_v_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// scanning from rr_ptr upward (wrapping) wins. Returns a one-hot grant and
// the winner's index. rr_ptr must be below NUM_REQ.
module riscv_v_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [PTR_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    // Scan requesters in priority order starting at rr_ptr; first hit wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_valid && req[cand]) begin
                grant_valid  = 1'b1;
                grant[cand]  = 1'b1;
                grant_idx    = PTR_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/riscv_v_rf_wb_arbiter.sv
// Vector RF writeback arbiter: round-robin shares the single RF write port
// between NUM_REQ writeback sources through one registered output stage,
// and exposes the in-flight write for RAW hazard detection.
// Optional build macro RISCV_V_WB_ARB_PERF_EN adds saturating conflict and
// stall performance counters.
module riscv_v_rf_wb_arbiter
    import riscv_v_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = RISCV_V_RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int NUM_BYTES  = RISCV_V_NUM_BYTES_DATA
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*NUM_BYTES-1:0]  req_be,
    output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
    output logic [DATA_WIDTH-1:0]         rf_data_in,
    output logic [NUM_BYTES-1:0]          rf_wr_en,
    output logic                          pend_valid,
    output logic [ADDR_WIDTH-1:0]         pend_addr
`ifdef RISCV_V_WB_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_conflict_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    localparam int PTR_WIDTH = $clog2(NUM_REQ);

    logic [PTR_WIDTH-1:0] rr_ptr;
    logic [PTR_WIDTH-1:0] next_ptr;
    logic [PTR_WIDTH-1:0] grant_idx;
    logic                 grant_valid;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    rf_wr_req_t           stage_q;
    logic                 stage_valid;

    // Reset and stall both suppress new grants; the output stage still drains.
    assign arb_req = (rst || wb_stall) ? '0 : req_valid;

    riscv_v_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (arb_req),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    // Pointer moves to the slot just after the winner, wrapping at NUM_REQ.
    always_comb begin
        next_ptr = grant_idx + 1'b1;
        if (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    // Output stage captures the winner's write; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            stage_valid <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            stage_valid <= grant_valid;
            if (grant_valid) begin
                stage_q.addr <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                stage_q.data <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                stage_q.be   <= req_be[grant_idx*NUM_BYTES +: NUM_BYTES];
                rr_ptr       <= next_ptr;
            end
        end
    end

    assign rf_wr_addr = stage_q.addr;
    assign rf_data_in = stage_q.data;
    assign rf_wr_en   = stage_valid ? stage_q.be : '0;
    assign pend_valid = stage_valid;
    assign pend_addr  = stage_q.addr;

`ifdef RISCV_V_WB_ARB_PERF_EN
    logic [2:0] num_valid;

    // Count how many requesters are contending this cycle.
    always_comb begin
        num_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            num_valid = num_valid + {2'b00, req_valid[i]};
        end
    end

    // Saturating event counters for contention and stall pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (num_valid >= 3'd2 && !wb_stall && perf_conflict_cnt != 32'hFFFF_FFFF) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (wb_stall && |req_valid && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
